// File: rtl/spike_encoder_pkg.sv
// Shared sizing, NO_SPIKE code and load-FSM encoding for the spike encoder.
// Optional SPIKE_ENC_THRESH_EN build macro: dim pixels (< THRESH) never spike.
package spike_encoder_pkg;
  localparam int NUM_SPIKES  = 16;
  localparam int PIX_W       = 8;
  localparam int LOG_T       = 3;
  localparam int TIME_PERIOD = 8;
  localparam int THRESH      = 16;
  localparam int ST_W        = LOG_T + 1;
  localparam int IDX_W       = $clog2(NUM_SPIKES);

  // One past the last valid time slot, so it never matches time_val.
  localparam logic [ST_W-1:0] NO_SPIKE = ST_W'(TIME_PERIOD);

  typedef logic [ST_W-1:0] spike_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } load_state_e;
endpackage

// File: rtl/spike_encoder_conv.sv
// Combinational pixel -> time-to-first-spike: bright pixels fire early.
// SPIKE_ENC_THRESH_EN: pixels below THRESH map to NO_SPIKE.
module spike_time_conv
  import spike_encoder_pkg::*;
(
  input  logic [PIX_W-1:0] pix,
  output spike_t           t
);
  logic [PIX_W-1:0] inv;
  spike_t           raw;

  // (2^PIX_W-1)-pix is the bitwise complement; the shift keeps the top LOG_T bits.
  assign inv = ~pix;
  assign raw = {1'b0, inv[PIX_W-1 -: LOG_T]};

`ifdef SPIKE_ENC_THRESH_EN
  assign t = (pix < PIX_W'(THRESH)) ? NO_SPIKE : raw;
`else
  assign t = raw;
`endif
endmodule

// File: rtl/spike_encoder.sv
// Double-buffered frame -> spike-time encoder; shadow fills from the pixel stream,
// active swaps in on the period boundary. Honours SPIKE_ENC_THRESH_EN via spike_time_conv.
module spike_encoder
  import spike_encoder_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [ST_W-1:0]            time_val,
  input  logic                       pix_valid,
  input  logic [PIX_W-1:0]           pix_data,
  input  logic                       pix_last,
  output logic                       pix_ready,
  output logic [NUM_SPIKES*ST_W-1:0] spike_times,
  output logic                       frame_valid,
  output logic                       frame_err
);
  load_state_e                         state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NUM_SPIKES-1:0][ST_W-1:0]     shadow_q, shadow_d;
  logic [NUM_SPIKES-1:0][ST_W-1:0]     active_q, active_d;
  logic                                frame_valid_q, frame_valid_d;
  logic                                frame_err_q, frame_err_d;

  spike_t conv_t;
  logic   accept, boundary, idx_last;

  spike_time_conv u_conv (
    .pix (pix_data),
    .t   (conv_t)
  );

  assign pix_ready = (state_q == FILL);
  assign accept    = pix_valid & pix_ready;
  assign boundary  = (time_val == ST_W'(TIME_PERIOD - 1));
  assign idx_last  = (idx_q == IDX_W'(NUM_SPIKES - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    frame_valid_d = frame_valid_q;
    frame_err_d   = frame_err_q;

    if (accept) begin
      shadow_d[idx_q] = conv_t;
      if (idx_last && pix_last) begin
        state_d = FULL;
      end else if (idx_last || pix_last) begin
        // Misframed: drop the partial frame and restart at pixel 0.
        frame_err_d = 1'b1;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // FULL never accepts, so this cannot collide with a final-pixel accept.
    if (boundary) begin
      if (state_q == FULL) begin
        active_d      = shadow_q;
        frame_valid_d = 1'b1;
        state_d       = FILL;
        idx_d         = '0;
      end else begin
        active_d      = {NUM_SPIKES{NO_SPIKE}};
        frame_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= FILL;
      idx_q         <= '0;
      shadow_q      <= {NUM_SPIKES{NO_SPIKE}};
      active_q      <= {NUM_SPIKES{NO_SPIKE}};
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign spike_times = active_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
endmodule
